// File: rtl/dmem_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module      : dmem_arbiter_if
//  Description : Bundle of the two requester handshakes (req/gnt/rvalid) and
//                the single-port data memory strobes used by dmem_arbiter.
//                modport master : the arbiter (sole master of the memory)
//                modport slave  : requesters plus the memory itself
//  Revision    : 1.0  initial release
// ============================================================================
interface dmem_arbiter_if #(
  parameter int DATA_W = 32
);
  // Requester port 0 (load/store unit)
  logic              req0_i;
  logic              we0_i;
  logic [31:0]       addr0_i;
  logic [DATA_W-1:0] wdata0_i;
  logic              gnt0_o;
  logic              rvalid0_o;
  logic [DATA_W-1:0] rdata0_o;
  logic              err0_o;

  // Requester port 1 (debug/loader)
  logic              req1_i;
  logic              we1_i;
  logic [31:0]       addr1_i;
  logic [DATA_W-1:0] wdata1_i;
  logic              gnt1_o;
  logic              rvalid1_o;
  logic [DATA_W-1:0] rdata1_o;
  logic              err1_o;

  // Memory side
  logic              MemRead;
  logic              MemWrite;
  logic [31:0]       ram_addr;
  logic [DATA_W-1:0] write_data;
  logic [DATA_W-1:0] read_data;

  modport master (
    input  req0_i, we0_i, addr0_i, wdata0_i,
    input  req1_i, we1_i, addr1_i, wdata1_i,
    output gnt0_o, rvalid0_o, rdata0_o, err0_o,
    output gnt1_o, rvalid1_o, rdata1_o, err1_o,
    output MemRead, MemWrite, ram_addr, write_data,
    input  read_data
  );

  modport slave (
    output req0_i, we0_i, addr0_i, wdata0_i,
    output req1_i, we1_i, addr1_i, wdata1_i,
    input  gnt0_o, rvalid0_o, rdata0_o, err0_o,
    input  gnt1_o, rvalid1_o, rdata1_o, err1_o,
    input  MemRead, MemWrite, ram_addr, write_data,
    output read_data
  );
endinterface
`default_nettype wire

// File: rtl/dmem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : dmem_arbiter
//  Description : Round-robin two-port arbiter/sequencer in front of a
//                single-port data memory. One access per two cycles:
//                gnt (IDLE) -> memory strobe (ACCESS) -> registered rvalid.
//                Out-of-range addresses raise err and never strobe memory.
//  Options     : DMEM_ARB_PERF_EN adds saturating reads/writes/stalls
//                counters (reads_o, writes_o, stalls_o).
//  Revision    : 1.0  initial release
// ============================================================================
module dmem_arbiter #(
  parameter int DEPTH  = 32,
  parameter int DATA_W = 32
) (
  input  logic           clk,
  input  logic           rst,
  dmem_arbiter_if.master bus
`ifdef DMEM_ARB_PERF_EN
  ,
  output logic [31:0]    reads_o,
  output logic [31:0]    writes_o,
  output logic [31:0]    stalls_o
`endif
);

  typedef enum logic [0:0] {
    ST_IDLE   = 1'b0,
    ST_ACCESS = 1'b1
  } state_t;

  localparam logic [31:0] c_depth = 32'(DEPTH);

  state_t            r_state;
  state_t            w_state_next;

  // Latched request (captured on grant)
  logic              r_last;      // last granted port, 1 after reset
  logic              r_port;
  logic              r_we;
  logic [31:0]       r_addr;
  logic [DATA_W-1:0] r_wdata;

  // Registered response
  logic              r_rvalid;
  logic              r_rport;
  logic              r_err;
  logic [DATA_W-1:0] r_rdata;

  logic              w_any_req;
  logic              w_pick1;
  logic              w_grant;
  logic              w_access;
  logic              w_in_range;
  logic              w_mem_read;
  logic              w_mem_write;
  logic              w_we_sel;
  logic [31:0]       w_addr_sel;
  logic [DATA_W-1:0] w_wdata_sel;

  // Next-state and grant decode; grant is masked by rst so it drops at once
  always_comb begin
    w_state_next = r_state;
    w_grant      = 1'b0;
    w_any_req    = bus.req0_i | bus.req1_i;
    // Port 1 wins when alone, or on a tie when port 0 was granted last
    w_pick1      = bus.req1_i & (~bus.req0_i | ~r_last);
    case (r_state)
      ST_IDLE: begin
        if (w_any_req && !rst) begin
          w_grant      = 1'b1;
          w_state_next = ST_ACCESS;
        end
      end
      ST_ACCESS: w_state_next = ST_IDLE;
      default:   w_state_next = ST_IDLE;
    endcase
  end

  // Request mux and memory strobe decode from registered state only
  always_comb begin
    w_we_sel    = w_pick1 ? bus.we1_i    : bus.we0_i;
    w_addr_sel  = w_pick1 ? bus.addr1_i  : bus.addr0_i;
    w_wdata_sel = w_pick1 ? bus.wdata1_i : bus.wdata0_i;
    w_access    = (r_state == ST_ACCESS);
    w_in_range  = (r_addr < c_depth);
    w_mem_read  = w_access & w_in_range & ~r_we;
    w_mem_write = w_access & w_in_range &  r_we;
  end

  assign bus.gnt0_o     = w_grant & ~w_pick1;
  assign bus.gnt1_o     = w_grant &  w_pick1;
  assign bus.MemRead    = w_mem_read;
  assign bus.MemWrite   = w_mem_write;
  assign bus.ram_addr   = r_addr;
  assign bus.write_data = r_wdata;

  assign bus.rvalid0_o  = r_rvalid & ~r_rport;
  assign bus.rvalid1_o  = r_rvalid &  r_rport;
  assign bus.rdata0_o   = (r_rvalid && !r_rport) ? r_rdata : '0;
  assign bus.rdata1_o   = (r_rvalid &&  r_rport) ? r_rdata : '0;
  assign bus.err0_o     = r_rvalid & ~r_rport & r_err;
  assign bus.err1_o     = r_rvalid &  r_rport & r_err;

  // FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_next;
  end

  // Capture the granted request and update the round-robin pointer
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_last  <= 1'b1;
      r_port  <= 1'b0;
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
    end else if (w_grant) begin
      r_last  <= w_pick1;
      r_port  <= w_pick1;
      r_we    <= w_we_sel;
      r_addr  <= w_addr_sel;
      r_wdata <= w_wdata_sel;
    end
  end

  // Register the response at the end of ACCESS; rvalid follows one cycle later
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rvalid <= 1'b0;
      r_rport  <= 1'b0;
      r_err    <= 1'b0;
      r_rdata  <= '0;
    end else begin
      r_rvalid <= w_access;
      if (w_access) begin
        r_rport <= r_port;
        r_err   <= ~w_in_range;
        r_rdata <= w_mem_read ? bus.read_data : '0;
      end
    end
  end

`ifdef DMEM_ARB_PERF_EN
  // Saturating performance counters
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      reads_o  <= '0;
      writes_o <= '0;
      stalls_o <= '0;
    end else begin
      if (w_mem_read && (reads_o != 32'hFFFF_FFFF))
        reads_o <= reads_o + 32'd1;
      if (w_mem_write && (writes_o != 32'hFFFF_FFFF))
        writes_o <= writes_o + 32'd1;
      if (w_any_req && !w_grant && (stalls_o != 32'hFFFF_FFFF))
        stalls_o <= stalls_o + 32'd1;
    end
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_dmem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_dmem_arbiter
//  Description : Self-checking bench for dmem_arbiter: directed scenarios
//                plus a randomized two-port run against a transaction-level
//                model (grant rules, memory contents, response timing).
//  Revision    : 1.0  initial release
// ============================================================================
module tb_dmem_arbiter;
  localparam int DEPTH  = 32;
  localparam int DATA_W = 32;

  typedef struct {
    int          due;
    bit          port;
    logic [31:0] rdata;
    bit          err;
  } resp_t;

  logic clk = 1'b0;
  logic rst;
  logic ram_clear;
  int   checks = 0;
  int   errors = 0;

  logic [31:0] ram     [0:DEPTH-1];
  logic [31:0] ref_mem [0:DEPTH-1];

  always #5 clk = ~clk;

  dmem_arbiter_if #(.DATA_W(DATA_W)) bus ();

`ifdef DMEM_ARB_PERF_EN
  logic [31:0] reads, writes, stalls;
  dmem_arbiter #(.DEPTH(DEPTH), .DATA_W(DATA_W)) dut (
    .clk(clk), .rst(rst), .bus(bus),
    .reads_o(reads), .writes_o(writes), .stalls_o(stalls)
  );
`else
  dmem_arbiter #(.DEPTH(DEPTH), .DATA_W(DATA_W)) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );
`endif

  function automatic logic [31:0] init_val(input int i);
    return (i % 2 == 1) ? (32'hA500_0000 | 32'(i)) : 32'h0;
  endfunction

  // Single-port memory: combinational read, write on posedge
  always @(posedge clk) begin
    if (ram_clear) begin
      for (int i = 0; i < DEPTH; i++) ram[i] <= init_val(i);
    end else if (bus.MemWrite && bus.ram_addr < 32'(DEPTH)) begin
      ram[bus.ram_addr[4:0]] <= bus.write_data;
    end
  end
  assign bus.read_data = (bus.ram_addr < 32'(DEPTH)) ? ram[bus.ram_addr[4:0]] : '0;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic sample;
    @(negedge clk);
  endtask

  task automatic drive(input int p, input logic r, input logic w,
                       input logic [31:0] a, input logic [31:0] d);
    if (p == 0) begin
      bus.req0_i = r; bus.we0_i = w; bus.addr0_i = a; bus.wdata0_i = d;
    end else begin
      bus.req1_i = r; bus.we1_i = w; bus.addr1_i = a; bus.wdata1_i = d;
    end
  endtask

  task automatic idle_ports;
    drive(0, 1'b0, 1'b0, 32'h0, 32'h0);
    drive(1, 1'b0, 1'b0, 32'h0, 32'h0);
  endtask

  task automatic test_reset;
    drive(0, 1'b1, 1'b1, 32'h4, 32'h1234);
    sample;
    checks++; if (bus.gnt0_o !== 1'b0) begin errors++; $display("FAIL rst_gnt0 got=%0b exp=0", bus.gnt0_o); end
    checks++; if (bus.gnt1_o !== 1'b0) begin errors++; $display("FAIL rst_gnt1 got=%0b exp=0", bus.gnt1_o); end
    checks++; if ({bus.rvalid0_o, bus.rvalid1_o, bus.err0_o, bus.err1_o} !== 4'b0)
      begin errors++; $display("FAIL rst_rvalid_err got=%b exp=0000", {bus.rvalid0_o, bus.rvalid1_o, bus.err0_o, bus.err1_o}); end
    checks++; if ({bus.MemRead, bus.MemWrite} !== 2'b0) begin errors++; $display("FAIL rst_strobes got=%b exp=00", {bus.MemRead, bus.MemWrite}); end
    checks++; if (bus.ram_addr !== 32'h0) begin errors++; $display("FAIL rst_ram_addr got=%h exp=0", bus.ram_addr); end
    checks++; if (bus.write_data !== 32'h0) begin errors++; $display("FAIL rst_write_data got=%h exp=0", bus.write_data); end
    checks++; if ({bus.rdata0_o, bus.rdata1_o} !== 64'h0) begin errors++; $display("FAIL rst_rdata got=%h exp=0", {bus.rdata0_o, bus.rdata1_o}); end
    idle_ports;
    tick;
    rst = 1'b0;
    tick;
  endtask

  task automatic test_write_read;
    drive(0, 1'b1, 1'b1, 32'd5, 32'hDEADBEEF);
    sample;
    checks++; if (bus.gnt0_o !== 1'b1) begin errors++; $display("FAIL wr_gnt0 got=%0b exp=1", bus.gnt0_o); end
    checks++; if (bus.gnt1_o !== 1'b0) begin errors++; $display("FAIL wr_gnt1 got=%0b exp=0", bus.gnt1_o); end
    checks++; if (bus.MemWrite !== 1'b0) begin errors++; $display("FAIL wr_early_memwrite got=%0b exp=0", bus.MemWrite); end
    tick;
    drive(0, 1'b0, 1'b0, $urandom, $urandom);
    sample;
    checks++; if ({bus.MemWrite, bus.MemRead} !== 2'b10) begin errors++; $display("FAIL wr_strobes got=%b exp=10", {bus.MemWrite, bus.MemRead}); end
    checks++; if (bus.ram_addr !== 32'd5) begin errors++; $display("FAIL wr_ram_addr got=%h exp=5", bus.ram_addr); end
    checks++; if (bus.write_data !== 32'hDEADBEEF) begin errors++; $display("FAIL wr_write_data got=%h exp=deadbeef", bus.write_data); end
    checks++; if (bus.rvalid0_o !== 1'b0) begin errors++; $display("FAIL wr_early_rvalid got=%0b exp=0", bus.rvalid0_o); end
    ref_mem[5] = 32'hDEADBEEF;
    tick;
    // The read is requested in the same cycle as the write acknowledge
    drive(0, 1'b1, 1'b0, 32'd5, 32'h0);
    sample;
    checks++; if (bus.rvalid0_o !== 1'b1) begin errors++; $display("FAIL wr_rvalid0 got=%0b exp=1", bus.rvalid0_o); end
    checks++; if (bus.rdata0_o !== 32'h0) begin errors++; $display("FAIL wr_rdata0 got=%h exp=0", bus.rdata0_o); end
    checks++; if (bus.err0_o !== 1'b0) begin errors++; $display("FAIL wr_err0 got=%0b exp=0", bus.err0_o); end
    checks++; if (bus.gnt0_o !== 1'b1) begin errors++; $display("FAIL rd_b2b_gnt0 got=%0b exp=1", bus.gnt0_o); end
    tick;
    drive(0, 1'b0, 1'b0, 32'h0, 32'h0);
    sample;
    checks++; if ({bus.MemWrite, bus.MemRead} !== 2'b01) begin errors++; $display("FAIL rd_strobes got=%b exp=01", {bus.MemWrite, bus.MemRead}); end
    tick;
    sample;
    checks++; if (bus.rvalid0_o !== 1'b1) begin errors++; $display("FAIL rd_rvalid0 got=%0b exp=1", bus.rvalid0_o); end
    checks++; if (bus.rdata0_o !== ref_mem[5]) begin errors++; $display("FAIL rd_rdata0 got=%h exp=%h", bus.rdata0_o, ref_mem[5]); end
    checks++; if (bus.err0_o !== 1'b0) begin errors++; $display("FAIL rd_err0 got=%0b exp=0", bus.err0_o); end
    tick;
    tick;
  endtask

  task automatic test_tie;
    drive(0, 1'b1, 1'b0, 32'd3, 32'h0);
    drive(1, 1'b1, 1'b0, 32'd7, 32'h0);
    rst = 1'b1;
    tick;
    tick;
    rst = 1'b0;
    sample;   // cycle 0
    checks++; if ({bus.gnt0_o, bus.gnt1_o} !== 2'b10) begin errors++; $display("FAIL tie_c0_gnt got=%b exp=10", {bus.gnt0_o, bus.gnt1_o}); end
    tick;
    drive(0, 1'b0, 1'b0, 32'h0, 32'h0);
    sample;   // cycle 1
    checks++; if ({bus.gnt0_o, bus.gnt1_o} !== 2'b00) begin errors++; $display("FAIL tie_c1_gnt got=%b exp=00", {bus.gnt0_o, bus.gnt1_o}); end
    checks++; if (bus.ram_addr !== 32'd3) begin errors++; $display("FAIL tie_c1_addr got=%h exp=3", bus.ram_addr); end
    tick;
    sample;   // cycle 2
    checks++; if ({bus.gnt0_o, bus.gnt1_o} !== 2'b01) begin errors++; $display("FAIL tie_c2_gnt got=%b exp=01", {bus.gnt0_o, bus.gnt1_o}); end
    checks++; if (bus.rvalid0_o !== 1'b1) begin errors++; $display("FAIL tie_c2_rvalid0 got=%0b exp=1", bus.rvalid0_o); end
    checks++; if (bus.rdata0_o !== ref_mem[3]) begin errors++; $display("FAIL tie_c2_rdata0 got=%h exp=%h", bus.rdata0_o, ref_mem[3]); end
    tick;
    drive(0, 1'b1, 1'b0, 32'd9, 32'h0);
    drive(1, 1'b1, 1'b0, 32'd11, 32'h0);
    sample;   // cycle 3
    checks++; if ({bus.gnt0_o, bus.gnt1_o} !== 2'b00) begin errors++; $display("FAIL tie_c3_gnt got=%b exp=00", {bus.gnt0_o, bus.gnt1_o}); end
    tick;
    sample;   // cycle 4
    checks++; if (bus.rvalid1_o !== 1'b1) begin errors++; $display("FAIL tie_c4_rvalid1 got=%0b exp=1", bus.rvalid1_o); end
    checks++; if (bus.rdata1_o !== ref_mem[7]) begin errors++; $display("FAIL tie_c4_rdata1 got=%h exp=%h", bus.rdata1_o, ref_mem[7]); end
    checks++; if ({bus.gnt0_o, bus.gnt1_o} !== 2'b10) begin errors++; $display("FAIL tie_c4_third_gnt got=%b exp=10", {bus.gnt0_o, bus.gnt1_o}); end
    tick;
    idle_ports;   // port 1 withdraws before being granted
    tick;
    sample;   // cycle 6
    checks++; if (bus.rdata0_o !== ref_mem[9] || bus.rvalid0_o !== 1'b1)
      begin errors++; $display("FAIL tie_c6_rdata0 got=%h/%0b exp=%h/1", bus.rdata0_o, bus.rvalid0_o, ref_mem[9]); end
    tick;
    sample;
    checks++; if ({bus.gnt1_o, bus.rvalid1_o} !== 2'b00) begin errors++; $display("FAIL tie_withdraw got=%b exp=00", {bus.gnt1_o, bus.rvalid1_o}); end
    tick;
  endtask

  task automatic test_out_of_range;
    int          tp [3] = '{1, 0, 0};
    logic        tw [3] = '{1'b0, 1'b1, 1'b0};
    logic [31:0] ta [3] = '{32'd32, 32'hFFFF_FFF0, 32'd31};
    for (int k = 0; k < 3; k++) begin
      logic        exp_err;
      logic [31:0] exp_rd;
      exp_err = (ta[k] >= 32'(DEPTH));
      exp_rd  = (exp_err || tw[k]) ? 32'h0 : ref_mem[ta[k][4:0]];
      drive(tp[k], 1'b1, tw[k], ta[k], 32'h5555_AAAA);
      sample;
      checks++; if ((tp[k] == 1 ? bus.gnt1_o : bus.gnt0_o) !== 1'b1) begin errors++; $display("FAIL oor%0d_gnt got=0 exp=1", k); end
      tick;
      drive(tp[k], 1'b0, 1'b0, 32'h0, 32'h0);
      sample;
      checks++; if ({bus.MemRead, bus.MemWrite} !== (exp_err ? 2'b00 : {~tw[k], tw[k]}))
        begin errors++; $display("FAIL oor%0d_strobes got=%b exp_err=%0b", k, {bus.MemRead, bus.MemWrite}, exp_err); end
      checks++; if (bus.ram_addr !== ta[k]) begin errors++; $display("FAIL oor%0d_ram_addr got=%h exp=%h", k, bus.ram_addr, ta[k]); end
      tick;
      sample;
      checks++; if ((tp[k] == 1 ? bus.rvalid1_o : bus.rvalid0_o) !== 1'b1) begin errors++; $display("FAIL oor%0d_rvalid got=0 exp=1", k); end
      checks++; if ((tp[k] == 1 ? bus.err1_o : bus.err0_o) !== exp_err)
        begin errors++; $display("FAIL oor%0d_err got=%0b exp=%0b", k, (tp[k] == 1 ? bus.err1_o : bus.err0_o), exp_err); end
      checks++; if ((tp[k] == 1 ? bus.rdata1_o : bus.rdata0_o) !== exp_rd)
        begin errors++; $display("FAIL oor%0d_rdata got=%h exp=%h", k, (tp[k] == 1 ? bus.rdata1_o : bus.rdata0_o), exp_rd); end
      checks++; if ({bus.MemRead, bus.MemWrite} !== 2'b00) begin errors++; $display("FAIL oor%0d_idle_strobes got=%b exp=00", k, {bus.MemRead, bus.MemWrite}); end
      tick;
    end
  endtask

  task automatic test_reset_mid_access;
    drive(0, 1'b1, 1'b1, 32'd2, 32'hCAFEF00D);
    sample;
    checks++; if (bus.gnt0_o !== 1'b1) begin errors++; $display("FAIL rma_gnt0 got=%0b exp=1", bus.gnt0_o); end
    tick;
    idle_ports;
    #1;
    checks++; if (bus.MemWrite !== 1'b1) begin errors++; $display("FAIL rma_memwrite_before got=%0b exp=1", bus.MemWrite); end
    #1;
    rst = 1'b1;
    #1;
    checks++; if ({bus.MemWrite, bus.MemRead} !== 2'b00) begin errors++; $display("FAIL rma_memwrite_async got=%b exp=00", {bus.MemWrite, bus.MemRead}); end
    checks++; if (bus.ram_addr !== 32'h0 || bus.write_data !== 32'h0)
      begin errors++; $display("FAIL rma_bus_cleared got=%h/%h exp=0/0", bus.ram_addr, bus.write_data); end
    tick;
    rst = 1'b0;
    for (int c = 0; c < 3; c++) begin
      sample;
      checks++; if ({bus.rvalid0_o, bus.rvalid1_o} !== 2'b00) begin errors++; $display("FAIL rma_no_rvalid c%0d got=%b exp=00", c, {bus.rvalid0_o, bus.rvalid1_o}); end
      tick;
    end
    drive(0, 1'b1, 1'b0, 32'd2, 32'h0);
    sample;
    checks++; if (bus.gnt0_o !== 1'b1) begin errors++; $display("FAIL rma_read_gnt0 got=%0b exp=1", bus.gnt0_o); end
    tick;
    idle_ports;
    tick;
    sample;
    checks++; if (bus.rvalid0_o !== 1'b1 || bus.rdata0_o !== ref_mem[2])
      begin errors++; $display("FAIL rma_read_rdata got=%h/%0b exp=%h/1", bus.rdata0_o, bus.rvalid0_o, ref_mem[2]); end
    tick;
  endtask

  task automatic test_fairness;
    drive(0, 1'b1, 1'b0, $urandom_range(0, 31), 32'h0);
    drive(1, 1'b1, 1'b0, $urandom_range(0, 31), 32'h0);
    rst = 1'b1;
    tick;
    tick;
    rst = 1'b0;
    for (int c = 0; c < 16; c++) begin
      logic [1:0] exp_g;
      exp_g = (c % 4 == 0) ? 2'b10 : (c % 4 == 2) ? 2'b01 : 2'b00;
      sample;
      checks++; if ({bus.gnt0_o, bus.gnt1_o} !== exp_g) begin errors++; $display("FAIL fair_c%0d_gnt got=%b exp=%b", c, {bus.gnt0_o, bus.gnt1_o}, exp_g); end
      checks++; if ({bus.MemRead, bus.MemWrite} !== {(c % 2 == 1), 1'b0})
        begin errors++; $display("FAIL fair_c%0d_strobes got=%b exp=%b", c, {bus.MemRead, bus.MemWrite}, {(c % 2 == 1), 1'b0}); end
      tick;
      if (exp_g[1]) bus.addr0_i = $urandom_range(0, 31);
      if (exp_g[0]) bus.addr1_i = $urandom_range(0, 31);
    end
    idle_ports;
    tick;
    tick;
    tick;
  endtask

  task automatic test_random;
    bit          act [2];
    logic        tw  [2];
    logic [31:0] ta  [2];
    logic [31:0] td  [2];
    bit          m_busy = 1'b0;
    bit          m_last = 1'b1;
    logic        c_we = 1'b0;
    logic [31:0] c_addr = 32'h0;
    logic [31:0] c_wdata = 32'h0;
    resp_t       q [$];
    resp_t       r;
    int          m_reads = 0, m_writes = 0, m_stalls = 0;
    act = '{1'b0, 1'b0};
    idle_ports;
    rst = 1'b1;
    tick;
    rst = 1'b0;
    for (int cyc = 0; cyc < 600; cyc++) begin
      bit any, pick, e_g0, e_g1, e_rd, e_wr, e_rv0, e_rv1, inr;
      for (int p = 0; p < 2; p++) begin
        if (!act[p]) begin
          if (cyc < 590 && $urandom_range(0, 2) == 0) begin
            act[p] = 1'b1;
            tw[p]  = 1'($urandom_range(0, 1));
            case ($urandom_range(0, 7))
              0:       ta[p] = 32'(32 + $urandom_range(0, 40));
              1:       ta[p] = $urandom;
              default: ta[p] = 32'($urandom_range(0, 31));
            endcase
            td[p] = $urandom;
          end
        end else if ($urandom_range(0, 15) == 0) begin
          act[p] = 1'b0;
        end
        drive(p, act[p], tw[p], ta[p], td[p]);
      end
      sample;
      any  = act[0] | act[1];
      pick = 1'b0; e_g0 = 1'b0; e_g1 = 1'b0;
      if (!m_busy && any) begin
        pick = (act[0] && act[1]) ? ~m_last : act[1];
        e_g0 = ~pick;
        e_g1 = pick;
      end
      checks++; if ({bus.gnt0_o, bus.gnt1_o} !== {e_g0, e_g1})
        begin errors++; $display("FAIL rnd_c%0d_gnt got=%b exp=%b", cyc, {bus.gnt0_o, bus.gnt1_o}, {e_g0, e_g1}); end
      inr  = (c_addr < 32'(DEPTH));
      e_rd = m_busy && inr && !c_we;
      e_wr = m_busy && inr && c_we;
      checks++; if ({bus.MemRead, bus.MemWrite} !== {e_rd, e_wr})
        begin errors++; $display("FAIL rnd_c%0d_strobes got=%b exp=%b", cyc, {bus.MemRead, bus.MemWrite}, {e_rd, e_wr}); end
      if (m_busy) begin
        checks++; if (bus.ram_addr !== c_addr) begin errors++; $display("FAIL rnd_c%0d_ram_addr got=%h exp=%h", cyc, bus.ram_addr, c_addr); end
        if (e_wr) begin
          checks++; if (bus.write_data !== c_wdata) begin errors++; $display("FAIL rnd_c%0d_wdata got=%h exp=%h", cyc, bus.write_data, c_wdata); end
        end
      end
      e_rv0 = (q.size() > 0) && (q[0].due == cyc) && !q[0].port;
      e_rv1 = (q.size() > 0) && (q[0].due == cyc) &&  q[0].port;
      checks++; if ({bus.rvalid0_o, bus.rvalid1_o} !== {e_rv0, e_rv1})
        begin errors++; $display("FAIL rnd_c%0d_rvalid got=%b exp=%b", cyc, {bus.rvalid0_o, bus.rvalid1_o}, {e_rv0, e_rv1}); end
      if (e_rv0 || e_rv1) begin
        r = q.pop_front();
        checks++; if ((e_rv1 ? bus.rdata1_o : bus.rdata0_o) !== r.rdata)
          begin errors++; $display("FAIL rnd_c%0d_rdata got=%h exp=%h", cyc, (e_rv1 ? bus.rdata1_o : bus.rdata0_o), r.rdata); end
        checks++; if ((e_rv1 ? bus.err1_o : bus.err0_o) !== r.err)
          begin errors++; $display("FAIL rnd_c%0d_err got=%0b exp=%0b", cyc, (e_rv1 ? bus.err1_o : bus.err0_o), r.err); end
      end
      m_reads  += int'(e_rd);
      m_writes += int'(e_wr);
      m_stalls += int'(any && !(e_g0 || e_g1));
      if (e_g0 || e_g1) begin
        m_last  = pick;
        c_we    = tw[pick];
        c_addr  = ta[pick];
        c_wdata = td[pick];
        r.due   = cyc + 2;
        r.port  = pick;
        r.err   = (c_addr >= 32'(DEPTH));
        r.rdata = 32'h0;
        if (!r.err) begin
          if (c_we) ref_mem[c_addr[4:0]] = c_wdata;
          else      r.rdata = ref_mem[c_addr[4:0]];
        end
        q.push_back(r);
        act[pick] = 1'b0;
      end
      m_busy = e_g0 || e_g1;
      tick;
    end
`ifdef DMEM_ARB_PERF_EN
    sample;
    checks++; if (reads !== 32'(m_reads)) begin errors++; $display("FAIL perf_reads got=%0d exp=%0d", reads, m_reads); end
    checks++; if (writes !== 32'(m_writes)) begin errors++; $display("FAIL perf_writes got=%0d exp=%0d", writes, m_writes); end
    checks++; if (stalls !== 32'(m_stalls)) begin errors++; $display("FAIL perf_stalls got=%0d exp=%0d", stalls, m_stalls); end
`endif
  endtask

  initial begin
    rst       = 1'b1;
    ram_clear = 1'b1;
    idle_ports;
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = init_val(i);
    tick;
    tick;
    ram_clear = 1'b0;
    test_reset;
    test_write_read;
    test_tie;
    test_out_of_range;
    test_reset_mid_access;
    test_fairness;
    test_random;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Two-requester arbiter and sequencer in front of the single-port data memory (32 words, combinational read, write on posedge clk).
- Port 0 is the load/store unit and port 1 is the debug/loader port. Each port uses a req/gnt/rvalid handshake.
- Grants are round-robin. The block drives the memory's MemRead/MemWrite/ram_addr/write_data for exactly one cycle per access and returns registered read data.
- The memory itself is unchanged; this block is its only master.

Parameters:
- DEPTH, 32: number of addressable 32-bit words in the memory; addresses >= DEPTH are errors.
- DATA_W, 32: data width of ports and memory.

Ports:
- clk  input  1  system clock, all state on posedge
- rst  input  1  asynchronous, active-high reset
- req0_i / req1_i  input  1  access request, held high until gnt
- we0_i / we1_i  input  1  1 = write, 0 = read; held with req
- addr0_i / addr1_i  input  32  word address; held with req
- wdata0_i / wdata1_i  input  DATA_W  write data; held with req
- gnt0_o / gnt1_o  output  1  one-cycle pulse; request accepted, inputs may change next cycle
- rvalid0_o / rvalid1_o  output  1  one-cycle pulse; access complete
- rdata0_o / rdata1_o  output  DATA_W  read data, valid with rvalid
- err0_o / err1_o  output  1  out-of-range flag, valid with rvalid
- MemRead  output  1  to memory
- MemWrite  output  1  to memory
- ram_addr  output  32  to memory
- write_data  output  DATA_W  to memory
- read_data  input  DATA_W  from memory

Behaviour:
- FSM states: IDLE, ACCESS.
  - IDLE: if any req is high, grant one port and latch its we/addr/wdata/port-id into internal registers. Pulse gnt for that port in this cycle (combinational from state and req). Next state is ACCESS. With no req, stay in IDLE.
  - ACCESS: drive ram_addr = latched addr and write_data = latched wdata.
    - In range: MemRead = ~we, MemWrite = we.
    - Out of range (addr >= DEPTH): MemRead = MemWrite = 0.
    - Always return to IDLE.
    - On the posedge ending ACCESS, register rdata = read_data for an in-range read, else 0. Register err = out-of-range.
    - In the following cycle, pulse rvalid of the latched port for one cycle.
- MemRead/MemWrite are 0 in IDLE and are decoded only from registered state. They never glitch high from req inputs.
- ram_addr and write_data hold their last latched values when idle.
- Latency: gnt in cycle N, memory access in N+1, rvalid/rdata in N+2.
- Throughput: one access per 2 cycles. A new grant may occur in the same cycle as the previous rvalid.
- Arbitration: a single req is granted immediately.
  - Both req in IDLE: grant the port that was not granted last.
  - The last-granted pointer resets to 1, so port 0 wins the first tie.
  - A port held high is never starved: maximum wait is one other access, i.e. 2 cycles.
- Writes: rvalid pulses as acknowledge, with rdata = 0.
- Out-of-range access: no memory strobe is driven. rvalid pulses with err = 1 and rdata = 0.
- Address: the full 32-bit addr is compared against DEPTH. ram_addr passes the latched address unmodified.
- Reset (asynchronous, any time): state = IDLE, pointer = 1, latched registers = 0.
  - All outputs go to 0 immediately: gnt, rvalid, rdata, err, MemRead, MemWrite, ram_addr, write_data.
  - An access in flight is dropped, with no rvalid and no memory write.
  - A req still held after reset release is granted normally.
- req deasserted before gnt is legal; nothing is latched.

Optional Feature:
- Macro: DMEM_ARB_PERF_EN.
- Defined: adds outputs reads_o[31:0], writes_o[31:0], stalls_o[31:0], all reset to 0 and saturating at 0xFFFFFFFF.
  - reads_o and writes_o increment at each in-range ACCESS cycle of that type.
  - stalls_o increments each cycle some req is high without a gnt.
- Undefined: these ports and counters do not exist. All other behaviour is identical.

Test Plan:
- Reset, then port0 write addr=5 data=0xDEADBEEF, then port0 read addr=5:
  - gnt at N, MemWrite=1 with ram_addr=5 at N+1, rvalid0 at N+2.
  - The read returns rdata0=0xDEADBEEF, err0=0.
- Both req high from reset, both reads of addr 3 and 7:
  - gnt0 at cycle 0, gnt1 at cycle 2, rvalid0 at 2, rvalid1 at 4.
  - A third tie is granted to port0.
- Port1 read addr=32 (DEPTH=32):
  - MemRead and MemWrite stay 0 throughout.
  - rvalid1=1, err1=1, rdata1=0 two cycles after gnt.
- Port0 write addr=2 with rst asserted mid-ACCESS, before the posedge:
  - MemWrite drops to 0 asynchronously and no rvalid0 occurs.
  - A subsequent read of addr 2 returns the prior value of 0.
- Port0 req held continuously while port1 pulses req every cycle:
  - Grants alternate 0,1,0,1 and each port waits at most 2 cycles.
  - MemRead/MemWrite are only ever high in ACCESS cycles.
- With DMEM_ARB_PERF_EN: 3 reads, 2 writes, 1 out-of-range read -> reads_o=3, writes_o=2. stalls_o equals the counted ungranted-req cycles.
